// File: rtl/i2c_temp_slave_if.sv
// I2C pin bundle between a bus master and the temperature-register target.
// SDA is open-drain: the target only reports whether it pulls the line low.
interface i2c_temp_slave_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_temp_slave.sv
// I2C target exposing a pointer-selected register set: temperature (RO),
// configuration, T_low and T_high, with 1- or 2-byte reads and writes.
module i2c_temp_slave #(
  parameter logic [6:0]  ADDR      = 7'h48,
  parameter logic [15:0] TLOW_RST  = 16'h4B00,
  parameter logic [15:0] THIGH_RST = 16'h5000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  i2c_temp_slave_if.slave        bus,
  input  logic [15:0]            i_temp,
  output logic [7:0]             o_config,
  output logic [15:0]            o_t_low,
  output logic [15:0]            o_t_high,
  output logic                   o_wr_strobe,
  output logic                   o_busy
);

  localparam int unsigned W_REG  = 16;
  localparam int unsigned W_BYTE = 8;
  localparam int unsigned W_CNT  = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_PTR, S_WR_MSB, S_WR_LSB, S_WR_NACK, S_RD_BYTE, S_RD_ACK
  } state_t;

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  state_t             r_state, w_state_nxt;
  logic [W_CNT-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [W_BYTE-1:0]  r_shift, w_shift_nxt;
  logic [W_BYTE-1:0]  r_stage, w_stage_nxt;
  logic [W_BYTE-1:0]  r_config, w_config_nxt;
  logic [W_REG-1:0]   r_t_low, w_t_low_nxt;
  logic [W_REG-1:0]   r_t_high, w_t_high_nxt;
  logic [W_REG-1:0]   r_shadow, w_shadow_nxt;
  logic [1:0]         r_ptr, w_ptr_nxt;
  logic               r_ack_ok, w_ack_ok_nxt;
  logic               r_ack_slot, w_ack_slot_nxt;
  logic               r_rd_lsb, w_rd_lsb_nxt;
  logic               r_wr_strobe, w_wr_strobe_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_sda_oe, w_sda_oe_nxt;

  // Two-stage synchronizers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= bus.scl_in; r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= bus.sda_in; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [W_BYTE-1:0] w_byte, w_cur_byte;
  logic [W_REG-1:0]  w_sel;
  logic              w_sel_msb, w_next_msb;
  state_t            w_after_ack;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = ~r_sda_s2 & r_sda_d & r_scl_s2;
  assign w_stop     = r_sda_s2 & ~r_sda_d & r_scl_s2;
  assign w_byte     = {r_shift[6:0], r_sda_s2};

  // Read source selection and the bit to present after each read byte boundary
  always_comb begin
    unique case (r_ptr)
      2'b00:   w_sel = i_temp;
      2'b01:   w_sel = {8'h00, r_config};
      2'b10:   w_sel = r_t_low;
      default: w_sel = r_t_high;
    endcase
  end
  assign w_sel_msb  = (r_ptr == 2'b01) ? w_sel[7] : w_sel[15];
  assign w_cur_byte = ((r_ptr == 2'b01) || r_rd_lsb) ? r_shadow[7:0] : r_shadow[15:8];
  assign w_next_msb = ((r_ptr != 2'b01) && r_rd_lsb) ? r_shadow[15] : r_shadow[7];

  always_comb begin
    unique case (r_state)
      S_PTR:    w_after_ack = S_WR_MSB;
      S_WR_MSB: w_after_ack = r_ptr[1] ? S_WR_LSB : S_WR_NACK;
      default:  w_after_ack = S_WR_NACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_stage     <= '0;
      r_config    <= 8'h00;
      r_t_low     <= TLOW_RST;
      r_t_high    <= THIGH_RST;
      r_shadow    <= '0;
      r_ptr       <= 2'b00;
      r_ack_ok    <= 1'b0;
      r_ack_slot  <= 1'b0;
      r_rd_lsb    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_busy      <= 1'b0;
      r_sda_oe    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_stage     <= w_stage_nxt;
      r_config    <= w_config_nxt;
      r_t_low     <= w_t_low_nxt;
      r_t_high    <= w_t_high_nxt;
      r_shadow    <= w_shadow_nxt;
      r_ptr       <= w_ptr_nxt;
      r_ack_ok    <= w_ack_ok_nxt;
      r_ack_slot  <= w_ack_slot_nxt;
      r_rd_lsb    <= w_rd_lsb_nxt;
      r_wr_strobe <= w_wr_strobe_nxt;
      r_busy      <= w_busy_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
    end
  end

  // Protocol FSM; bus conditions override any SCL edge seen in the same cycle
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_stage_nxt     = r_stage;
    w_config_nxt    = r_config;
    w_t_low_nxt     = r_t_low;
    w_t_high_nxt    = r_t_high;
    w_shadow_nxt    = r_shadow;
    w_ptr_nxt       = r_ptr;
    w_ack_ok_nxt    = r_ack_ok;
    w_ack_slot_nxt  = r_ack_slot;
    w_rd_lsb_nxt    = r_rd_lsb;
    w_wr_strobe_nxt = 1'b0;
    w_busy_nxt      = r_busy;
    w_sda_oe_nxt    = r_sda_oe;

    if (w_start || w_stop) begin
      w_state_nxt    = w_start ? S_ADDR : S_IDLE;
      w_bit_cnt_nxt  = '0;
      w_ack_slot_nxt = 1'b0;
      w_sda_oe_nxt   = 1'b0;
      w_busy_nxt     = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR: begin
          if (w_scl_rise && (r_bit_cnt < W_CNT'(8))) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + W_CNT'(1);
          end else if (w_scl_fall && (r_bit_cnt == W_CNT'(8))) begin
            if (r_shift[7:1] == ADDR) begin
              w_state_nxt  = S_ACK_ADDR;
              w_sda_oe_nxt = 1'b1;
              w_busy_nxt   = 1'b1;
            end else begin
              w_state_nxt  = S_IDLE;
            end
          end
        end
        S_ACK_ADDR: begin
          if (w_scl_fall) begin
            w_bit_cnt_nxt = '0;
            if (r_shift[0]) begin
              w_shadow_nxt = w_sel;
              w_rd_lsb_nxt = 1'b0;
              w_sda_oe_nxt = ~w_sel_msb;
              w_state_nxt  = S_RD_BYTE;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_PTR;
            end
          end
        end
        S_PTR, S_WR_MSB, S_WR_LSB, S_WR_NACK: begin
          if (w_scl_rise && (r_bit_cnt < W_CNT'(8))) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + W_CNT'(1);
            if (r_bit_cnt == W_CNT'(7)) begin
              w_ack_ok_nxt = 1'b0;
              if (r_state == S_PTR) begin
                w_ptr_nxt    = w_byte[1:0];
                w_ack_ok_nxt = 1'b1;
              end else if (r_state == S_WR_MSB && r_ptr == 2'b01) begin
                w_config_nxt    = w_byte;
                w_wr_strobe_nxt = 1'b1;
                w_ack_ok_nxt    = 1'b1;
              end else if (r_state == S_WR_MSB && r_ptr[1]) begin
                w_stage_nxt  = w_byte;
                w_ack_ok_nxt = 1'b1;
              end else if (r_state == S_WR_LSB) begin
                if (r_ptr[0]) w_t_high_nxt = {r_stage, w_byte};
                else          w_t_low_nxt  = {r_stage, w_byte};
                w_wr_strobe_nxt = 1'b1;
                w_ack_ok_nxt    = 1'b1;
              end
            end
          end else if (w_scl_fall) begin
            if (r_ack_slot) begin
              w_ack_slot_nxt = 1'b0;
              w_sda_oe_nxt   = 1'b0;
              w_bit_cnt_nxt  = '0;
              w_state_nxt    = w_after_ack;
            end else if (r_bit_cnt == W_CNT'(8)) begin
              w_ack_slot_nxt = 1'b1;
              w_sda_oe_nxt   = r_ack_ok;
            end
          end
        end
        S_RD_BYTE: begin
          if (w_scl_rise && (r_bit_cnt < W_CNT'(8))) begin
            w_bit_cnt_nxt = r_bit_cnt + W_CNT'(1);
          end else if (w_scl_fall) begin
            if (r_bit_cnt == W_CNT'(8)) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_RD_ACK;
            end else begin
              w_sda_oe_nxt = ~w_cur_byte[3'(W_CNT'(7) - r_bit_cnt)];
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (r_sda_s2) w_state_nxt    = S_IDLE;
            else          w_ack_slot_nxt = 1'b1;
          end else if (w_scl_fall && r_ack_slot) begin
            w_ack_slot_nxt = 1'b0;
            w_bit_cnt_nxt  = '0;
            w_rd_lsb_nxt   = (r_ptr == 2'b01) ? 1'b0 : ~r_rd_lsb;
            w_sda_oe_nxt   = ~w_next_msb;
            w_state_nxt    = S_RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe  = r_sda_oe;
  assign o_config    = r_config;
  assign o_t_low     = r_t_low;
  assign o_t_high    = r_t_high;
  assign o_wr_strobe = r_wr_strobe;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_i2c_temp_slave.sv
// Bench for i2c_temp_slave: a bit-banged I2C master with a transaction-level
// model of the register file predicting ACKs, read data and register contents.
module tb_i2c_temp_slave;
  localparam int unsigned Q = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drv_scl = 1'b1;
  logic        drv_sda = 1'b1;
  logic [15:0] temp = 16'h0000;
  logic [7:0]  cfg;
  logic [15:0] tlo, thi;
  logic        strobe, busy;

  i2c_temp_slave_if bus ();
  assign bus.scl_in = drv_scl;
  assign bus.sda_in = drv_sda & ~bus.sda_oe;

  i2c_temp_slave dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .i_temp(temp),
    .o_config(cfg), .o_t_low(tlo), .o_t_high(thi),
    .o_wr_strobe(strobe), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int strobe_pulses = 0, strobe_cycles = 0, oe_cycles = 0;
  logic strobe_q = 1'b0;

  always @(posedge clk) begin
    if (strobe) strobe_cycles = strobe_cycles + 1;
    if (strobe && !strobe_q) strobe_pulses = strobe_pulses + 1;
    strobe_q = strobe;
    if (bus.sda_oe) oe_cycles = oe_cycles + 1;
  end

  // Reference register file
  logic [1:0]  md_ptr = 2'b00;
  logic [7:0]  md_cfg = 8'h00, md_stage = 8'h00;
  logic [15:0] md_tlo = 16'h4B00, md_thi = 16'h5000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic start_c();
    drv_sda = 1'b1; wq(); drv_scl = 1'b1; wq(); drv_sda = 1'b0; wq(); drv_scl = 1'b0; wq();
  endtask

  task automatic stop_c();
    drv_sda = 1'b0; wq(); drv_scl = 1'b1; wq(); drv_sda = 1'b1; wq();
  endtask

  task automatic wbit(input logic b);
    drv_sda = b; wq(); drv_scl = 1'b1; wq(); wq(); drv_scl = 1'b0; wq();
  endtask

  task automatic rbit(output logic b);
    drv_sda = 1'b1; wq(); drv_scl = 1'b1; wq(); b = bus.sda_in; wq(); drv_scl = 1'b0; wq();
  endtask

  task automatic wbyte(input logic [7:0] v, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) wbit(v[i]);
    rbit(x);
    ack = ~x;
  endtask

  task automatic rbyte(output logic [7:0] v, input logic ack);
    logic x;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin rbit(x); v = {v[6:0], x}; end
    wbit(~ack);
  endtask

  task automatic model_reset();
    md_ptr = 2'b00; md_cfg = 8'h00; md_tlo = 16'h4B00; md_thi = 16'h5000;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_cfg"}, 32'(cfg), 32'(md_cfg));
    chk({tag, "_tlow"}, 32'(tlo), 32'(md_tlo));
    chk({tag, "_thigh"}, 32'(thi), 32'(md_thi));
  endtask

  // Write n bytes (pointer first) to address 0x48
  task automatic xfer_write(input int n, input logic [7:0] d0, d1, d2, d3, input logic no_stop);
    logic [7:0] d[4];
    logic ack, exp_ack;
    int s0, commits;
    d = '{d0, d1, d2, d3};
    s0 = strobe_pulses;
    commits = 0;
    start_c();
    wbyte(8'h90, ack);
    chk("wr_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      exp_ack = 1'b0;
      if (i == 0) begin
        exp_ack = 1'b1; md_ptr = d[0][1:0];
      end else if (md_ptr == 2'b01 && i == 1) begin
        exp_ack = 1'b1; md_cfg = d[i]; commits++;
      end else if (md_ptr[1] && i == 1) begin
        exp_ack = 1'b1; md_stage = d[i];
      end else if (md_ptr[1] && i == 2) begin
        exp_ack = 1'b1; commits++;
        if (md_ptr[0]) md_thi = {md_stage, d[i]};
        else           md_tlo = {md_stage, d[i]};
      end
      wbyte(d[i], ack);
      chk("wr_data_ack", 32'(ack), 32'(exp_ack));
    end
    chk("wr_busy_high", 32'(busy), 32'd1);
    if (!no_stop) begin
      stop_c();
      chk("wr_busy_low", 32'(busy), 32'd0);
    end
    chk_regs("wr");
    chk("wr_strobe_count", 32'(strobe_pulses - s0), 32'(commits));
    chk("wr_strobe_width", 32'(strobe_cycles), 32'(strobe_pulses));
  endtask

  // Read n bytes; optionally scramble Temp_in after the first byte
  task automatic xfer_read(input int n, input logic change);
    logic [15:0] snap;
    logic [7:0] v, exp;
    logic ack;
    case (md_ptr)
      2'b00:   snap = temp;
      2'b10:   snap = md_tlo;
      2'b11:   snap = md_thi;
      default: snap = {8'h00, md_cfg};
    endcase
    start_c();
    wbyte(8'h91, ack);
    chk("rd_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (md_ptr == 2'b01) exp = md_cfg;
      else exp = (i % 2 == 0) ? snap[15:8] : snap[7:0];
      rbyte(v, i < n - 1);
      chk("rd_data", 32'(v), 32'(exp));
      if (change && i == 0) temp = 16'($urandom);
    end
    chk("rd_nack_release", 32'(bus.sda_oe), 32'd0);
    stop_c();
    chk("rd_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    logic ack;
    int oe0, s0;
    logic [7:0] lsb;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    wq();

    chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk_regs("rst");

    // T_low write through pointer 10
    xfer_write(3, 8'h02, 8'h12, 8'h34, 8'h00, 1'b0);
    chk("tlow_value", 32'(tlo), 32'h1234);

    // Pointer 00, repeated START, snapshot read of Temp_in
    temp = 16'hABCD;
    xfer_write(1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    xfer_read(2, 1'b1);

    // Config write, extra byte NACKed, repeated config reads
    xfer_write(3, 8'h01, 8'h60, 8'h77, 8'h00, 1'b0);
    chk("cfg_value", 32'(cfg), 32'h60);
    xfer_read(3, 1'b0);

    // Foreign address 0x4A
    oe0 = oe_cycles;
    start_c();
    wbyte(8'h94, ack);
    chk("foreign_no_ack", 32'(ack), 32'd0);
    chk("foreign_busy", 32'(busy), 32'd0);
    wbyte(8'h02, ack);
    stop_c();
    chk("foreign_oe_idle", 32'(oe_cycles - oe0), 32'd0);
    chk("foreign_busy_end", 32'(busy), 32'd0);

    // Write to read-only pointer 00
    xfer_write(2, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0);

    // Randomized mix of writes and reads
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1)
        xfer_write(int'($urandom_range(1, 4)), 8'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom), 1'b0);
      else begin
        temp = 16'($urandom);
        xfer_read(int'($urandom_range(1, 3)), 1'b1);
      end
    end

    // Reset during the 5th bit of a T_high LSB write
    s0 = strobe_pulses;
    start_c();
    wbyte(8'h90, ack);
    wbyte(8'h03, ack);
    wbyte(8'hAA, ack);
    chk("thigh_msb_ack", 32'(ack), 32'd1);
    lsb = 8'h5C;
    for (int i = 7; i >= 4; i--) wbit(lsb[i]);
    drv_sda = lsb[3]; wq(); drv_scl = 1'b1; wq();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_regs("midrst");
    chk("midrst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_no_strobe", 32'(strobe_pulses - s0), 32'd0);
    drv_scl = 1'b0; wq(); drv_sda = 1'b1; wq(); drv_scl = 1'b1; wq();
    rst_n = 1'b1;
    wq();
    temp = 16'($urandom);
    xfer_read(2, 1'b0);
    xfer_write(3, 8'h03, 8'($urandom), 8'($urandom), 8'h00, 1'b0);
    xfer_read(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/i2c_temp_slave.md
# i2c_temp_slave

I2C target (slave) for the temperature-sensor register set used by the bus master control unit: a pointer register selecting one of four registers (temperature, configuration, T_low, T_high), with one-byte or two-byte reads and writes. It sits on the shared SCL/SDA lines opposite the master and drives SDA only through an open-drain enable. It exposes the writable registers to the rest of the design and samples the live temperature word.

## Interface
- ADDR, 7'h48, 7-bit bus address the block answers to
- TLOW_RST, 16'h4B00, reset value of T_low
- THIGH_RST, 16'h5000, reset value of T_high

- Clk  in  1  system clock; must be at least 10x the SCL frequency
- Rst  in  1  asynchronous active-low reset
- Scl_in  in  1  SCL line level, asynchronous
- Sda_in  in  1  SDA line level, asynchronous
- Sda_oe  out  1  1 = pull SDA low; 0 = release
- Temp_in  in  16  live temperature word (register 00, read-only)
- Config  out  8  configuration register (pointer 01)
- T_low  out  16  T_low register (pointer 10)
- T_high  out  16  T_high register (pointer 11)
- Wr_strobe  out  1  one-Clk pulse when Config, T_low or T_high is updated
- Busy  out  1  1 from an address match until STOP or a new START

## Operation
- Scl_in and Sda_in each pass through a 2-FF synchronizer, then a third register for edge detection.
- START: synchronized SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognized in any state.
- START goes to ADDR and clears the bit counter. STOP goes to IDLE and drops Sda_oe.
- Bits are sampled on synchronized SCL rising edges, MSB first.
- Sda_oe changes only on synchronized SCL falling edges.
- A 4-bit bit counter runs 0..8. Bit 8 is the ACK slot.
- States:
  - IDLE: Sda_oe=0; wait for START.
  - ADDR: shift 7 address bits plus RW. On match go to ACK_ADDR and drive ACK. On mismatch go to IDLE with no ACK.
  - ACK_ADDR: on the following SCL falling edge, release SDA (RW=0) or drive read bit 7 (RW=1). If RW=1, latch the read shadow, which is Temp_in, Config, T_low or T_high per the pointer.
  - PTR: receive 8 bits. Store bits[1:0] as pointer; bits[7:2] are ignored. ACK.
  - WR_MSB: receive 8 bits. Pointer 01: write Config at ACK, then go to WR_NACK. Pointer 1x: hold the byte in a staging register, ACK, go to WR_LSB. Pointer 00: NACK, go to WR_NACK.
  - WR_LSB: receive 8 bits. At ACK, commit {staging, byte} atomically to T_low (10) or T_high (11), pulse Wr_strobe, go to WR_NACK.
  - WR_NACK: NACK every further byte.
  - RD_BYTE: drive 8 bits from the shadow. Drive 0 as Sda_oe=1; drive 1 as release.
  - RD_ACK: release SDA and sample the master ACK. If ACK, continue with the next byte: for 16-bit registers alternate MSB, LSB, MSB...; pointer 01 repeats Config. If NACK, go to IDLE.
- The pointer persists across transactions and resets to 00. A repeated START after the pointer byte keeps the new pointer, so the write-pointer-then-read sequence works.
- The read shadow is captured once per read transaction, so MSB and LSB come from the same sample.
- Reset mid-transfer: all state returns to reset values immediately and SDA is released.

## Timing
- Reset values:
  - Sda_oe=0, Busy=0, Wr_strobe=0, pointer=00
  - Config=8'h00, T_low=TLOW_RST, T_high=THIGH_RST
  - FSM in IDLE
- Pin-to-detection latency is 3 Clk (2 synchronizer stages plus the edge register). The Sda_oe update is registered one Clk after the detected SCL falling edge.
- Address ACK: Sda_oe=1 from the SCL fall after bit 0 (RW) until the SCL fall after the 9th clock.
- Wr_strobe is exactly one Clk wide, asserted the Clk after the SCL rising edge of the final data bit.
- Config/T_low/T_high change in the same Clk that Wr_strobe asserts.
- Busy rises with the address ACK drive and falls within 1 Clk of STOP detection.
- START and STOP in the same synchronized sample cannot occur. If SCL and SDA edges are detected in the same Clk, the SCL edge is ignored and the START/STOP takes priority.

## Test plan
- Write with pointer 10 (address byte 0x90, then 0x02, 0x12, 0x34, STOP) -> ACK on all four bytes; T_low=16'h1234; exactly one Wr_strobe pulse; Busy returns to 0 after STOP.
- Pointer write 0x00, repeated START, address byte 0x91, two reads with Temp_in=16'hABCD that changes mid-read -> bytes 0xAB then 0xCD (captured snapshot); master NACK -> IDLE, Sda_oe=0.
- Config path: write 0x90, 0x01, 0x60 -> Config=8'h60; a further byte 0x77 is NACKed and Config stays 8'h60; then reading 3 bytes returns 0x60, 0x60, 0x60.
- Address 0x4A with write (byte 0x94) -> no ACK; Sda_oe stays 0 for the whole frame; Busy stays 0.
- Write to pointer 00 (0x90, 0x00, 0x55) -> pointer byte ACKed, data byte NACKed, no Wr_strobe.
- Assert Rst during the 5th bit of a T_high LSB write -> T_high=THIGH_RST, Sda_oe=0, pointer=00; the next full transaction completes normally.
